// File: rtl/demosaic_seq_ctrl.sv
// demosaic_seq_ctrl: frame sequencer for the 2x2 demosaic datapath and its
// 2-row line buffer. It gates line-buffer shifts, primes two rows, and tracks
// output x/y and Bayer phase. After the last input pixel it flushes two rows
// of zeros so that every output pixel of the frame is produced.
// Optional feature macro: DEMOSAIC_SEQ_BORDER_EN (frame-edge flag on oBorder).
//
// state  | meaning
// IDLE   | waiting for iStart
// PRIME  | filling the two line-buffer rows, no outputs yet
// ACTIVE | every input shift yields one output pixel
// FLUSH  | shifting zeros for two rows to drain the last outputs
// DONE   | one cycle before returning to IDLE, raises oFrameDone
module demosaic_seq_ctrl #(
  parameter int         WIDTH   = 320,
  parameter int         HEIGHT  = 240,
  parameter logic [1:0] PATTERN = 2'b00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iStart,
  input  logic        iValid,
  output logic        oShiftEn,
  output logic        oFlush,
  output logic        oOutValid,
  output logic [15:0] oX,
  output logic [15:0] oY,
  output logic [1:0]  oPhase,
  output logic        oBorder,
  output logic        oBusy,
  output logic        oFrameDone,
  output logic        oOverrun
);

  localparam logic [31:0] PRIME_N = 32'(2 * WIDTH);
  localparam logic [31:0] LAST_IN = 32'(WIDTH * HEIGHT - 1);
  localparam logic [31:0] LAST_S  = 32'(WIDTH * (HEIGHT + 2) - 1);
  localparam logic [15:0] X_LAST  = 16'(WIDTH - 1);
  localparam logic [15:0] Y_LAST  = 16'(HEIGHT - 1);

  typedef enum logic [2:0] {IDLE, PRIME, ACTIVE, FLUSH, DONE} state_t;

  state_t      state;
  logic [31:0] s;
  logic [15:0] nx;
  logic [15:0] ny;
  logic        start_ok;
  logic        out_fire;

  // Line-buffer clock enable and zero-injection select, decoded from state.
  always_comb begin
    oShiftEn = 1'b0;
    oFlush   = 1'b0;
    case (state)
      PRIME, ACTIVE: oShiftEn = iValid;
      FLUSH: begin
        oShiftEn = 1'b1;
        oFlush   = 1'b1;
      end
      default: ;
    endcase
  end

  // A start coinciding with the frame-done pulse is dropped.
  assign start_ok = (state == IDLE) && iStart && !oFrameDone;
  assign out_fire = oShiftEn && (s >= PRIME_N);

  // Sequencer state, shift count and registered output coordinates.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      s          <= '0;
      nx         <= '0;
      ny         <= '0;
      oOutValid  <= 1'b0;
      oX         <= '0;
      oY         <= '0;
      oPhase     <= '0;
      oBusy      <= 1'b0;
      oFrameDone <= 1'b0;
      oOverrun   <= 1'b0;
`ifdef DEMOSAIC_SEQ_BORDER_EN
      oBorder    <= 1'b0;
`endif
    end else begin
      oOutValid  <= out_fire;
      oFrameDone <= (state == DONE);
      if (oShiftEn) s <= s + 32'd1;
      if (out_fire) begin
        oX     <= nx;
        oY     <= ny;
        oPhase <= {ny[0], nx[0]} ^ PATTERN;
`ifdef DEMOSAIC_SEQ_BORDER_EN
        oBorder <= (nx == 16'd0) || (nx == X_LAST) || (ny == 16'd0) || (ny == Y_LAST);
`endif
        if (nx == X_LAST) begin
          nx <= '0;
          ny <= (ny == Y_LAST) ? 16'd0 : ny + 16'd1;
        end else begin
          nx <= nx + 16'd1;
        end
      end
      case (state)
        IDLE: begin
          if (start_ok) begin
            state    <= PRIME;
            s        <= '0;
            nx       <= '0;
            ny       <= '0;
            oOverrun <= 1'b0;
            oBusy    <= 1'b1;
          end
        end
        PRIME: begin
          // Tiny frames (HEIGHT==2) run out of input while still priming.
          if (oShiftEn && s == LAST_IN) state <= FLUSH;
          else if (oShiftEn && s == PRIME_N - 32'd1) state <= ACTIVE;
        end
        ACTIVE: begin
          if (oShiftEn && s == LAST_IN) state <= FLUSH;
        end
        FLUSH: begin
          if (iValid) oOverrun <= 1'b1;
          if (s == LAST_S) state <= DONE;
        end
        DONE: begin
          if (iValid) oOverrun <= 1'b1;
          state <= IDLE;
          oBusy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef DEMOSAIC_SEQ_BORDER_EN
  assign oBorder = 1'b0;
`endif

endmodule
